imem_loader: RTL and testbench

Host-side writer for the pipelined CPU's parallel instruction-image input. Accepts 32-bit instruction words one at a time over a valid/ready stream and packs them MSB-first into the flat instruction-image bus, with word 0 in the top slot. Unused slots are zero-filled. It then releases the CPU by raising `start`. It sits between the bench/host stream and the CPU top-level, replacing hand-assigned image slices.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/imem_slot_writer.sv | 37 +++
 rtl/imem_loader.sv | 128 ++++++++++++
 tb/tb_imem_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, NOP encoding, loader state enum, opcodes.
// Ports: none (package only).
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the CHK and ERR loader states.
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam logic [31:0] NOP = 32'h0;

  // Opcode / funct fields used to build instruction words
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PAD  = 3'd2,
    ST_RUN  = 3'd3
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    ST_CHK  = 3'd4,
    ST_ERR  = 3'd5
`endif
  } loader_state_t;

endpackage

// File: rtl/imem_slot_writer.sv
// Packed instruction-image register: decodes the slot index into a write enable
// per slot and clears the whole image on request. Slot k sits at
// bits [(N-k)*W-1 : (N-k-1)*W], so slot 0 is the top word.
// Ports: clock, reset_n (async active-low), clear, wr_en, wr_slot, wr_data, image.
module imem_slot_writer #(
  parameter int NUM_WORDS = 10,
  parameter int WORD_W    = 32
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 clear,
  input  logic                                 wr_en,
  input  logic [$clog2(NUM_WORDS+1)-1:0]       wr_slot,
  input  logic [WORD_W-1:0]                    wr_data,
  output logic [NUM_WORDS*WORD_W-1:0]          image
);
  import cpu_pkg::*;

  localparam int CW = $clog2(NUM_WORDS + 1);

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_slot
    logic [WORD_W-1:0] slot_q;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        slot_q <= WORD_W'(NOP);
      end else if (clear) begin
        slot_q <= WORD_W'(NOP);
      end else if (wr_en && (wr_slot == CW'(k))) begin
        slot_q <= wr_data;
      end
    end

    assign image[(NUM_WORDS-k)*WORD_W-1 -: WORD_W] = slot_q;
  end

endmodule

// File: rtl/imem_loader.sv
// Host-side instruction-image loader: packs a valid/ready word stream MSB-first
// into the CPU's flat image bus, zero-fills unused slots, then raises start.
// Ports: clock, reset_n (async active-low), wr_valid/wr_ready/wr_data/wr_last
// stream, restart, in_instruction, start, load_count, error.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (XOR checksum word after the program).
module imem_loader #(
  parameter int NUM_WORDS = 10,
  parameter int WORD_W    = cpu_pkg::WORD_W
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [WORD_W-1:0]              wr_data,
  input  logic                           wr_last,
  input  logic                           restart,
  output logic [NUM_WORDS*WORD_W-1:0]    in_instruction,
  output logic                           start,
  output logic [$clog2(NUM_WORDS+1)-1:0] load_count,
  output logic                           error
);
  import cpu_pkg::*;

  localparam int CW = $clog2(NUM_WORDS + 1);

  loader_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accepting;
  logic          hs;
  logic          wr_en;
  logic          clear;
  logic          last_word;
  loader_state_t exit_state;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] xor_q, xor_d;
  assign accepting  = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_CHK);
  assign exit_state = ST_CHK;
  assign error      = (state_q == ST_ERR);
`else
  assign accepting  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign exit_state = ST_PAD;
  assign error      = 1'b0;
`endif

  // restart masks ready so a word offered alongside restart is never taken
  assign wr_ready   = accepting && !restart;
  assign hs         = wr_valid && wr_ready;
  assign start      = (state_q == ST_RUN);
  assign load_count = cnt_q;

  // The word being written now fills the last slot when cnt_q == N-1
  assign last_word  = wr_last || (cnt_q == CW'(NUM_WORDS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    clear   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d   = xor_q;
`endif
    if (restart) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      clear   = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_d   = '0;
`endif
    end else begin
      case (state_q)
        // IDLE and LOAD behave identically on a handshake; a single-word
        // program with wr_last exits straight from IDLE.
        ST_IDLE, ST_LOAD: begin
          if (hs) begin
            wr_en   = 1'b1;
            cnt_d   = cnt_q + CW'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_d   = xor_q ^ wr_data;
`endif
            state_d = last_word ? exit_state : ST_LOAD;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (hs) begin
            state_d = (wr_data == xor_q) ? ST_PAD : ST_ERR;
          end
        end
        ST_ERR:  state_d = ST_ERR;
`endif
        ST_PAD:  state_d = ST_RUN;
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  imem_slot_writer #(
    .NUM_WORDS (NUM_WORDS),
    .WORD_W    (WORD_W)
  ) u_slot_writer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .wr_en   (wr_en),
    .wr_slot (cnt_q),
    .wr_data (wr_data),
    .image   (in_instruction)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
// Build with IMEM_LOADER_CHECKSUM_EN defined to exercise the checksum path.
module tb_imem_loader;
  import cpu_pkg::*;

  localparam int NW = 10;
  localparam int W  = 32;
  localparam int CW = $clog2(NW + 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [W-1:0]    wr_data = '0;
  logic            wr_last = 1'b0;
  logic            restart = 1'b0;
  logic [NW*W-1:0] in_instruction;
  logic            start;
  logic [CW-1:0]   load_count;
  logic            error;

  int errors = 0;
  int checks = 0;

  imem_loader #(.NUM_WORDS(NW), .WORD_W(W)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_data        (wr_data),
    .wr_last        (wr_last),
    .restart        (restart),
    .in_instruction (in_instruction),
    .start          (start),
    .load_count     (load_count),
    .error          (error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [NW*W-1:0] act, input logic [NW*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] slot(input logic [NW*W-1:0] img, input int k);
    return img[(NW-k)*W-1 -: W];
  endfunction

  // ---------------- reference model ----------------
  // Program = queue of accepted words; the image is that list top-aligned.
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_x = '0;
  bit           m_done = 0;   // program complete (wr_last or full)
  bit           m_chk = 0;    // waiting for checksum word
  bit           m_err = 0;
  int           m_since = 0;  // edges since program became runnable

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n || restart) begin
      m_q.delete(); m_x = '0; m_done = 0; m_chk = 0; m_err = 0; m_since = 0;
    end else if (!m_done) begin
      if (wr_valid) begin
        m_q.push_back(wr_data);
        m_x = m_x ^ wr_data;
        if (wr_last || m_q.size() == NW) begin
          m_done = 1; m_since = 0; m_chk = CHK_EN;
        end
      end
    end else if (m_chk) begin
      if (wr_valid) begin
        m_chk = 0;
        if (wr_data == m_x) m_since = 0;
        else m_err = 1;
      end
    end else if (m_since < 2) begin
      m_since++;
    end
  end

  always @(negedge clock) begin
    logic [NW*W-1:0] e_img;
    e_img = '0;
    for (int k = 0; k < m_q.size(); k++) e_img[(NW-k)*W-1 -: W] = m_q[k];
    chk("model_ready", {{(NW*W-1){1'b0}}, wr_ready},
        {{(NW*W-1){1'b0}}, ((!m_done || m_chk) && !restart)});
    chk("model_start", {{(NW*W-1){1'b0}}, start},
        {{(NW*W-1){1'b0}}, (m_done && !m_chk && !m_err && m_since >= 1)});
    chk("model_error", {{(NW*W-1){1'b0}}, error}, {{(NW*W-1){1'b0}}, m_err});
    chk("model_count", {{(NW*W-CW){1'b0}}, load_count}, (NW*W)'(m_q.size()));
    chk("model_image", in_instruction, e_img);
  end

  // ---------------- stimulus ----------------
  // Drive inputs for one cycle; returns 1 ns after the following falling edge.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic l, input logic r);
    wr_valid = v; wr_data = d; wr_last = l; restart = r;
    @(negedge clock); #1;
  endtask

  logic [W-1:0] words[12];
  logic [W-1:0] x;

  initial begin
    @(negedge clock); #1;
    chk("reset_ready", {319'b0, wr_ready}, 320'd1);
    chk("reset_start", {319'b0, start}, 320'd0);
    chk("reset_image", in_instruction, '0);
    chk("reset_count", {316'b0, load_count}, 320'd0);
    chk("reset_error", {319'b0, error}, 320'd0);
    reset_n = 1'b1;
    cyc(0, 0, 0, 0);

    // Basic load: 8 words, last on the 8th
    words[0] = {OP_SW, 26'b0};
    words[1] = {OP_LW, 5'd1, 5'd2, 16'h0004};
    words[2] = {OP_ADDI, 5'd3, 5'd3, 16'h0001};
    words[3] = {OP_ORI, 5'd4, 5'd5, 16'h00FF};
    words[4] = {OP_RTYPE, 5'd1, 5'd2, 5'd3, 5'd0, FN_SUB};
    words[5] = {OP_RTYPE, 5'd4, 5'd5, 5'd6, 5'd0, FN_AND};
    words[6] = $urandom;
    words[7] = $urandom;
    for (int i = 0; i < 8; i++) cyc(1, words[i], i == 7, 0);
    chk("basic_pad_start", {319'b0, start}, 320'd0);
    chk("basic_pad_ready", {319'b0, wr_ready}, CHK_EN ? 320'd1 : 320'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    x = '0;
    for (int i = 0; i < 8; i++) x ^= words[i];
    cyc(1, x, 0, 0);
`endif
    cyc(0, 0, 0, 0);
    chk("basic_start", {319'b0, start}, 320'd1);
    chk("basic_slot0", {288'b0, slot(in_instruction, 0)}, {288'b0, 32'hAC000000});
    chk("basic_slot7", {288'b0, slot(in_instruction, 7)}, {288'b0, words[7]});
    chk("basic_slot8_9", {256'b0, slot(in_instruction, 8), slot(in_instruction, 9)}, 320'd0);
    chk("basic_count", {316'b0, load_count}, 320'd8);

    // Restart in RUN
    cyc(0, 0, 0, 1);
    chk("rst_run_start", {319'b0, start}, 320'd0);
    chk("rst_run_image", in_instruction, '0);
    chk("rst_run_count", {316'b0, load_count}, 320'd0);

    // Overflow: 12 words, no wr_last
    for (int i = 0; i < 12; i++) words[i] = $urandom;
    for (int i = 0; i < 12; i++) begin
      cyc(1, words[i], 0, 0);
      if (i == 9) chk("ovf_ready_after_10", {319'b0, wr_ready}, CHK_EN ? 320'd1 : 320'd0);
    end
`ifndef IMEM_LOADER_CHECKSUM_EN
    chk("ovf_start", {319'b0, start}, 320'd1);
`endif
    chk("ovf_count", {316'b0, load_count}, 320'd10);
    chk("ovf_slot9", {288'b0, slot(in_instruction, 9)}, {288'b0, words[9]});
    cyc(0, 0, 0, 1);

    // Gaps: valid every other cycle, 4 words
    for (int i = 0; i < 4; i++) begin
      cyc(1, words[i], 0, 0);
      chk("gap_count", {316'b0, load_count}, 320'(i + 1));
      cyc(0, 32'hFFFF_FFFF, 0, 0);
      chk("gap_count_hold", {316'b0, load_count}, 320'(i + 1));
    end
    for (int i = 0; i < 4; i++) chk("gap_slot", {288'b0, slot(in_instruction, i)}, {288'b0, words[i]});

    // Restart mid-LOAD together with a valid word
    cyc(1, 32'hDEAD_BEEF, 0, 1);
    chk("rst_load_image", in_instruction, '0);
    chk("rst_load_count", {316'b0, load_count}, 320'd0);
    chk("rst_load_start", {319'b0, start}, 320'd0);

    // Async reset during LOAD
    for (int i = 0; i < 3; i++) cyc(1, words[i], 0, 0);
    wr_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_image", in_instruction, '0);
    chk("arst_count", {316'b0, load_count}, 320'd0);
    chk("arst_start", {319'b0, start}, 320'd0);
    chk("arst_ready", {319'b0, wr_ready}, 320'd1);
    cyc(0, 0, 0, 0);
    reset_n = 1'b1;
    cyc(0, 0, 0, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    for (int pass = 0; pass < 2; pass++) begin
      x = '0;
      for (int i = 0; i < 3; i++) begin
        words[i] = $urandom;
        x ^= words[i];
        cyc(1, words[i], i == 2, 0);
      end
      chk("cs_chk_ready", {319'b0, wr_ready}, 320'd1);
      cyc(1, (pass == 0) ? x : (x ^ 32'd1), 0, 0);
      cyc(0, 0, 0, 0);
      chk("cs_start", {319'b0, start}, (pass == 0) ? 320'd1 : 320'd0);
      chk("cs_error", {319'b0, error}, (pass == 0) ? 320'd0 : 320'd1);
      if (pass == 1) chk("cs_err_ready", {319'b0, wr_ready}, 320'd0);
      cyc(0, 0, 0, 1);
      chk("cs_recover", {319'b0, error}, 320'd0);
    end
`endif

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 5) == 0,
          $urandom_range(0, 24) == 0);
    end
    cyc(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
